dm_stack_unit: RTL and testbench

Parametrised data memory for the next-generation computer. It replaces the fixed 8-bit DM with configurable width and depth. It adds a hardware stack region (PUSH/POP) with full/empty flags and sticky overflow/underflow error, plus an asynchronous operand read port that feeds the ALU for ADD A,(Dir)-style instructions. It sits between the control unit/register file and the ALU mux.

---
 rtl/dm_pkg.sv | 14 +
 rtl/stack_ctrl.sv | 66 ++++++
 rtl/dm_stack_unit.sv | 100 ++++++++++
 tb/tb_dm_stack_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared op encoding and default widths for the data memory and the control unit.
package dm_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_STACK_DEPTH = 16;

endpackage

// File: rtl/stack_ctrl.sv
// Stack bookkeeping: entry count, stack pointer, full/empty decode and sticky error.
module stack_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned STACK_BASE  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err,
  output logic              push_ok,
  output logic              pop_ok
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  if (STACK_DEPTH == 0 || STACK_DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("stack_ctrl: STACK_DEPTH must be in 1 .. 2**ADDR_W");
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  always_comb begin
    stack_full  = (count_q == CNT_W'(STACK_DEPTH));
    stack_empty = (count_q == '0);
    push_ok     = push & ~stack_full;
    pop_ok      = pop & ~stack_empty;
    // Modulo-2**ADDR_W arithmetic: the stack grows downward from STACK_BASE.
    sp          = ADDR_W'(STACK_BASE) - ADDR_W'(count_q);
    stack_err   = err_q;
  end

  always_comb begin
    count_d = count_q;
    if (push_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok) begin
      count_d = count_q - CNT_W'(1);
    end
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    // A new error in the same cycle as err_clr wins.
    if ((push & stack_full) | (pop & stack_empty)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/dm_stack_unit.sv
// Parametrised data memory with a downward-growing hardware stack and an async operand port.
module dm_stack_unit
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int unsigned STACK_BASE  = 2 ** ADDR_W - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic [ADDR_W-1:0] oaddr,
  output logic [DATA_W-1:0] odata,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err,
  input  logic              err_clr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              is_load, is_store, is_push, is_pop;
  logic              push_ok, pop_ok;
  logic [ADDR_W-1:0] pop_addr;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_push  = 1'b0;
    is_pop   = 1'b0;
    case (op)
      OP_LOAD:  is_load  = 1'b1;
      OP_STORE: is_store = 1'b1;
      OP_PUSH:  is_push  = 1'b1;
      OP_POP:   is_pop   = 1'b1;
      default:  ;
    endcase
  end

  stack_ctrl #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .STACK_BASE  (STACK_BASE)
  ) u_stack_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (is_push),
    .pop         (is_pop),
    .err_clr     (err_clr),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err),
    .push_ok     (push_ok),
    .pop_ok      (pop_ok)
  );

  // sp points at the next free slot, so the top entry sits one above it.
  assign pop_addr = sp + ADDR_W'(1);

  // Array is deliberately not reset so preloaded contents survive rst_n.
  always_ff @(posedge clk) begin
    if (is_store) begin
      mem[addr] <= wdata;
    end else if (push_ok) begin
      mem[sp] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (is_load) begin
        rdata_q  <= mem[addr];
        rvalid_q <= 1'b1;
      end else if (pop_ok) begin
        rdata_q  <= mem[pop_addr];
        rvalid_q <= 1'b1;
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign odata  = mem[oaddr];

endmodule

// File: tb/tb_dm_stack_unit.sv
// Scoreboard bench for dm_stack_unit: expected read data queued at issue, checked on rvalid.
module tb_dm_stack_unit;
  import dm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] op = OP_NOP;
  logic [7:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       rvalid;
  logic [7:0] oaddr = '0;
  logic [7:0] odata;
  logic [7:0] sp;
  logic       stack_full, stack_empty, stack_err;
  logic       err_clr = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];

  dm_stack_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .oaddr       (oaddr),
    .odata       (odata),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one op for one clock edge; returns at the following negedge.
  task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] d);
    op    = o;
    addr  = a;
    wdata = d;
    @(posedge clk);
    @(negedge clk);
    op      = OP_NOP;
    err_clr = 1'b0;
  endtask

  // Monitor: every rvalid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && rvalid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rvalid: got rdata %0d expected no response", rdata);
      end else begin
        check("rdata_scoreboard", int'(rdata), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pre [6];
    pre = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_rdata", int'(rdata), 0);
    check("rst_rvalid", int'(rvalid), 0);
    check("rst_sp", int'(sp), 255);
    check("rst_empty", int'(stack_empty), 1);
    check("rst_full", int'(stack_full), 0);
    check("rst_err", int'(stack_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // STORE / LOAD, odata one cycle after STORE
    oaddr = 8'd50;
    do_op(OP_STORE, 8'd50, 8'd99);
    check("odata_after_store", int'(odata), 99);
    check("store_no_rvalid", int'(rvalid), 0);
    exp_q.push_back(8'd99);
    do_op(OP_LOAD, 8'd50, 8'd0);
    check("load_rvalid", int'(rvalid), 1);
    do_op(OP_NOP, 8'd0, 8'd0);
    check("rvalid_one_cycle", int'(rvalid), 0);

    // Overwrite and edge values
    do_op(OP_STORE, 8'd50, 8'd255);
    exp_q.push_back(8'd255);
    do_op(OP_LOAD, 8'd50, 8'd0);
    do_op(OP_STORE, 8'd10, 8'd0);
    exp_q.push_back(8'd0);
    do_op(OP_LOAD, 8'd10, 8'd0);

    // No bypass: same-cycle STORE to oaddr shows old value
    do_op(OP_STORE, 8'd60, 8'd3);
    oaddr = 8'd60;
    op = OP_STORE; addr = 8'd60; wdata = 8'd7;
    #1;
    check("odata_no_bypass", int'(odata), 3);
    do_op(OP_STORE, 8'd60, 8'd7);
    check("odata_new_value", int'(odata), 7);

    // PUSH 11, 22, 33 then POP x3
    do_op(OP_PUSH, 8'd0, 8'd11);
    check("sp_push1", int'(sp), 254);
    check("not_empty", int'(stack_empty), 0);
    do_op(OP_PUSH, 8'd0, 8'd22);
    do_op(OP_PUSH, 8'd0, 8'd33);
    check("sp_push3", int'(sp), 252);
    exp_q.push_back(8'd33);
    do_op(OP_POP, 8'd0, 8'd0);
    check("sp_pop1", int'(sp), 253);
    exp_q.push_back(8'd22);
    do_op(OP_POP, 8'd0, 8'd0);
    exp_q.push_back(8'd11);
    do_op(OP_POP, 8'd0, 8'd0);
    check("sp_pop3", int'(sp), 255);
    check("empty_after_pops", int'(stack_empty), 1);

    // Fill to full, overflow must not touch mem[239]
    do_op(OP_STORE, 8'd239, 8'hA5);
    for (int i = 0; i < 16; i++) do_op(OP_PUSH, 8'd0, 8'(i + 1));
    check("full", int'(stack_full), 1);
    check("sp_full", int'(sp), 239);
    check("err_before_ovf", int'(stack_err), 0);
    do_op(OP_PUSH, 8'd0, 8'hEE);
    check("ovf_err", int'(stack_err), 1);
    check("ovf_sp_held", int'(sp), 239);
    oaddr = 8'd239;
    #1;
    check("ovf_no_write", int'(odata), 8'hA5);
    err_clr = 1'b1;
    do_op(OP_NOP, 8'd0, 8'd0);
    check("err_clr", int'(stack_err), 0);
    for (int i = 16; i > 0; i--) begin
      exp_q.push_back(8'(i));
      do_op(OP_POP, 8'd0, 8'd0);
    end
    check("empty_after_drain", int'(stack_empty), 1);

    // Underflow: rdata held, no rvalid, sticky error
    do_op(OP_POP, 8'd0, 8'd0);
    check("unf_err", int'(stack_err), 1);
    check("unf_rvalid", int'(rvalid), 0);
    check("unf_rdata_held", int'(rdata), 1);
    do_op(OP_NOP, 8'd0, 8'd0);
    check("err_sticky", int'(stack_err), 1);
    err_clr = 1'b1;
    do_op(OP_NOP, 8'd0, 8'd0);
    check("err_clr2", int'(stack_err), 0);
    err_clr = 1'b1;
    do_op(OP_POP, 8'd0, 8'd0);
    check("err_wins_over_clr", int'(stack_err), 1);
    err_clr = 1'b1;
    do_op(OP_NOP, 8'd0, 8'd0);

    // Preload mem[0..5], three PUSHes, then async reset between edges
    for (int i = 0; i < 6; i++) do_op(OP_STORE, 8'(i), pre[i]);
    do_op(OP_PUSH, 8'd0, 8'd4);
    do_op(OP_PUSH, 8'd0, 8'd5);
    do_op(OP_PUSH, 8'd0, 8'd6);
    check("sp_before_rst", int'(sp), 252);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sp", int'(sp), 255);
    check("async_rst_empty", int'(stack_empty), 1);
    check("async_rst_rdata", int'(rdata), 0);
    check("async_rst_rvalid", int'(rvalid), 0);
    for (int i = 0; i < 6; i++) begin
      oaddr = 8'(i);
      #1;
      check("preload_odata", int'(odata), int'(pre[i]));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
